// File: rtl/ddr4_dq_dir_sched_if.sv
// Column-command channel into the DQ/DQS direction scheduler: handshake plus
// the per-command latency and burst configuration latched at acceptance.
interface ddr4_dq_dir_sched_if #(
  parameter int LAT_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [LAT_W-1:0] cfg_cl;
  logic [LAT_W-1:0] cfg_cwl;
  logic [LAT_W-1:0] cfg_al;
  logic             cfg_bc4;
  logic             cfg_pre2;

  modport master (
    output cmd_valid, cmd_wr, cfg_cl, cfg_cwl, cfg_al, cfg_bc4, cfg_pre2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_wr, cfg_cl, cfg_cwl, cfg_al, cfg_bc4, cfg_pre2,
    output cmd_ready
  );
endinterface

// File: rtl/ddr4_dq_dir_sched.sv
// DDR4 DQ/DQS bus direction scheduler: shifting timelines turn accepted column
// commands into write output enables and read drive windows, dropping collisions.
module ddr4_dq_dir_sched_chk (
  input logic ck,
  input logic rst,
  input logic dqs_oe,
  input logic rd_dqs_en,
  input logic collide,
  input logic cfg_err
);
  // Controller and model must never drive DQS together.
  a_no_contention: assert property (@(posedge ck) disable iff (rst) !(dqs_oe && rd_dqs_en));
  // A dropped command reports exactly one cause.
  a_one_drop_cause: assert property (@(posedge ck) disable iff (rst) !(collide && cfg_err));
endmodule

module ddr4_dq_dir_sched #(
  parameter int DEPTH = 64,
  parameter int LAT_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             ck,
  input  logic             rst,
  ddr4_dq_dir_sched_if.slave cmd,
  output logic             dqs_oe,
  output logic             dq_oe,
  output logic             rd_dqs_en,
  output logic             rd_dq_en,
  output logic             busy,
  output logic             collide,
  output logic             cfg_err,
  output logic [CNT_W-1:0] collide_cnt
);
  // Bit k of each timeline marks activity k+1 cycles from the current one.
  logic [DEPTH-1:0] wr_dqs, wr_dq, rd_dqs, rd_dq;
  logic [DEPTH-1:0] wr_dqs_sh, wr_dq_sh, rd_dqs_sh, rd_dq_sh;
  logic [DEPTH-1:0] wr_dqs_nx, wr_dq_nx, rd_dqs_nx, rd_dq_nx;
  logic [DEPTH-1:0] dqs_mask, dq_mask;
  logic             acc, bad, hit, do_err, do_col, do_add;
  int               lat, pre, bl, first, last;

  assign cmd.cmd_ready = ~rst;

  // Window arithmetic, legality and collision checks against post-shift slots.
  always_comb begin
    wr_dqs_sh = wr_dqs >> 1;
    wr_dq_sh  = wr_dq >> 1;
    rd_dqs_sh = rd_dqs >> 1;
    rd_dq_sh  = rd_dq >> 1;
    lat   = cmd.cmd_wr ? (32'(cmd.cfg_cwl) + 32'(cmd.cfg_al))
                       : (32'(cmd.cfg_cl) + 32'(cmd.cfg_al));
    pre   = cmd.cfg_pre2 ? 32'd2 : 32'd1;
    bl    = cmd.cfg_bc4 ? 32'd2 : 32'd4;
    first = lat - pre;
    last  = lat + bl;
    bad   = (first < 32'sd1) || (last + 32'sd1 > DEPTH - 1);
    dqs_mask = '0;
    dq_mask  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dqs_mask[k] = (k >= first - 1) && (k <= last - 1);
      dq_mask[k]  = (k >= lat - 1) && (k <= lat + bl - 2);
    end
    if (cmd.cmd_wr) begin
      hit = |(dqs_mask & rd_dqs_sh);
    end else begin
      hit = |(dqs_mask & wr_dqs_sh);
    end
    acc    = cmd.cmd_valid && !rst;
    do_err = acc && bad;
    do_col = acc && !bad && hit;
    do_add = acc && !bad && !hit;
    wr_dqs_nx = wr_dqs_sh;
    wr_dq_nx  = wr_dq_sh;
    rd_dqs_nx = rd_dqs_sh;
    rd_dq_nx  = rd_dq_sh;
    if (do_add && cmd.cmd_wr) begin
      wr_dqs_nx = wr_dqs_sh | dqs_mask;
      wr_dq_nx  = wr_dq_sh | dq_mask;
    end else if (do_add) begin
      rd_dqs_nx = rd_dqs_sh | dqs_mask;
      rd_dq_nx  = rd_dq_sh | dq_mask;
    end else begin
      wr_dqs_nx = wr_dqs_sh;
    end
  end

  // Timeline advance, registered enables and drop reporting.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_dqs      <= '0;
      wr_dq       <= '0;
      rd_dqs      <= '0;
      rd_dq       <= '0;
      dqs_oe      <= 1'b0;
      dq_oe       <= 1'b0;
      rd_dqs_en   <= 1'b0;
      rd_dq_en    <= 1'b0;
      busy        <= 1'b0;
      collide     <= 1'b0;
      cfg_err     <= 1'b0;
      collide_cnt <= '0;
    end else begin
      wr_dqs    <= wr_dqs_nx;
      wr_dq     <= wr_dq_nx;
      rd_dqs    <= rd_dqs_nx;
      rd_dq     <= rd_dq_nx;
      dqs_oe    <= wr_dqs_nx[0];
      dq_oe     <= wr_dq_nx[0];
      rd_dqs_en <= rd_dqs_nx[0];
      rd_dq_en  <= rd_dq_nx[0];
      busy      <= |(wr_dqs_nx | wr_dq_nx | rd_dqs_nx | rd_dq_nx);
      collide   <= do_col;
      cfg_err   <= do_err;
      if (do_col && (collide_cnt != {CNT_W{1'b1}})) begin
        collide_cnt <= collide_cnt + CNT_W'(1);
      end else begin
        collide_cnt <= collide_cnt;
      end
    end
  end

  ddr4_dq_dir_sched_chk u_chk (
    .ck       (ck),
    .rst      (rst),
    .dqs_oe   (dqs_oe),
    .rd_dqs_en(rd_dqs_en),
    .collide  (collide),
    .cfg_err  (cfg_err)
  );
endmodule

// File: tb/tb_ddr4_dq_dir_sched.sv
// Directed bench: an absolute-cycle reference model pushes per-cycle expectations
// to a scoreboard queue that is popped and compared against the DUT each cycle.
module tb_ddr4_dq_dir_sched;
  localparam int N = 1024;
  localparam int DEPTH = 64;

  typedef struct {
    int          cyc;
    logic        wdqs, wdq, rdqs, rdq, busy, col, err, rdy;
    logic [15:0] cnt;
  } exp_t;

  logic        ck = 1'b0;
  logic        rst;
  logic        dqs_oe, dq_oe, rd_dqs_en, rd_dq_en, busy, collide, cfg_err;
  logic [15:0] collide_cnt;

  ddr4_dq_dir_sched_if #(.LAT_W(6)) cif ();

  ddr4_dq_dir_sched #(.DEPTH(DEPTH), .LAT_W(6), .CNT_W(16)) dut (
    .ck         (ck),
    .rst        (rst),
    .cmd        (cif),
    .dqs_oe     (dqs_oe),
    .dq_oe      (dq_oe),
    .rd_dqs_en  (rd_dqs_en),
    .rd_dq_en   (rd_dq_en),
    .busy       (busy),
    .collide    (collide),
    .cfg_err    (cfg_err),
    .collide_cnt(collide_cnt)
  );

  always #5 ck = ~ck;

  logic        m_wdqs[N], m_wdq[N], m_rdqs[N], m_rdq[N], m_col[N], m_err[N];
  logic [15:0] m_cnt[N];
  exp_t        sbq[$];
  int          cyc, checks, passes, fails;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_cmd(input logic wr);
    int l, p, b, fst, lst, t;
    logic hit;
    t   = cyc;
    l   = wr ? (int'(cif.cfg_cwl) + int'(cif.cfg_al)) : (int'(cif.cfg_cl) + int'(cif.cfg_al));
    p   = cif.cfg_pre2 ? 2 : 1;
    b   = cif.cfg_bc4 ? 2 : 4;
    fst = t + l - p;
    lst = t + l + b;
    if ((l - p < 1) || (l + b + 1 > DEPTH - 1)) begin
      m_err[t+1] = 1'b1;
    end else begin
      hit = 1'b0;
      for (int c = fst; c <= lst; c++) hit |= wr ? m_rdqs[c] : m_wdqs[c];
      if (hit) begin
        m_col[t+1] = 1'b1;
        for (int c = t + 1; c < N; c++) if (m_cnt[c] != 16'hffff) m_cnt[c] += 16'd1;
      end else begin
        for (int c = fst; c <= lst; c++) begin
          if (wr) m_wdqs[c] = 1'b1;
          else m_rdqs[c] = 1'b1;
        end
        for (int c = t + l; c <= t + l + b - 1; c++) begin
          if (wr) m_wdq[c] = 1'b1;
          else m_rdq[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic wr, input logic r);
    exp_t e, g;
    e.cyc  = cyc;
    e.wdqs = m_wdqs[cyc];
    e.wdq  = m_wdq[cyc];
    e.rdqs = m_rdqs[cyc];
    e.rdq  = m_rdq[cyc];
    e.col  = m_col[cyc];
    e.err  = m_err[cyc];
    e.cnt  = m_cnt[cyc];
    e.rdy  = !r;
    e.busy = 1'b0;
    for (int c = cyc; c < N; c++) e.busy |= m_wdqs[c] | m_wdq[c] | m_rdqs[c] | m_rdq[c];
    sbq.push_back(e);
    cif.cmd_valid = v;
    cif.cmd_wr    = wr;
    rst           = r;
    if (r) begin
      for (int c = cyc + 1; c < N; c++) begin
        m_wdqs[c] = 1'b0; m_wdq[c] = 1'b0; m_rdqs[c] = 1'b0; m_rdq[c] = 1'b0;
        m_col[c] = 1'b0; m_err[c] = 1'b0; m_cnt[c] = 16'd0;
      end
    end else if (v) begin
      model_cmd(wr);
    end
    @(negedge ck);
    g = sbq.pop_front();
    chk("dqs_oe", 16'(dqs_oe), 16'(g.wdqs));
    chk("dq_oe", 16'(dq_oe), 16'(g.wdq));
    chk("rd_dqs_en", 16'(rd_dqs_en), 16'(g.rdqs));
    chk("rd_dq_en", 16'(rd_dq_en), 16'(g.rdq));
    chk("busy", 16'(busy), 16'(g.busy));
    chk("collide", 16'(collide), 16'(g.col));
    chk("cfg_err", 16'(cfg_err), 16'(g.err));
    chk("cmd_ready", 16'(cif.cmd_ready), 16'(g.rdy));
    chk("collide_cnt", collide_cnt, g.cnt);
    @(posedge ck);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int cl, input int cwl, input int al, input logic bc4, input logic pre2);
    cif.cfg_cl   = 6'(cl);
    cif.cfg_cwl  = 6'(cwl);
    cif.cfg_al   = 6'(al);
    cif.cfg_bc4  = bc4;
    cif.cfg_pre2 = pre2;
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0;
    for (int c = 0; c < N; c++) begin
      m_wdqs[c] = 1'b0; m_wdq[c] = 1'b0; m_rdqs[c] = 1'b0; m_rdq[c] = 1'b0;
      m_col[c] = 1'b0; m_err[c] = 1'b0; m_cnt[c] = 16'd0;
    end
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_wr    = 1'b0;
    cfg(11, 9, 0, 1'b0, 1'b0);
    @(posedge ck);
    #1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    // Single BL8 write, CWL=9, pre1.
    step(1'b1, 1'b1, 1'b0);
    idle(16);
    // BC4 read, CL=11, AL=2, pre2.
    cfg(11, 9, 2, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(18);
    // Write then read one cycle later: read collides.
    cfg(11, 9, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(16);
    // Back-to-back writes at tCCD=4 merge.
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(20);
    // Illegal latencies: too short, then too long.
    cfg(11, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(2);
    cfg(60, 9, 3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    // Read window touching the write's final slot collides; one cycle later it fits.
    cfg(2, 9, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(11);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(10);
    // Reset in the middle of a write burst.
    cfg(11, 9, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(9);
    step(1'b0, 1'b0, 1'b1);
    idle(8);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
